// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer: FSM states, opcodes,
// datapath select codes and the one-hot instruction class produced by mc_decode.
package multicycle_ctrl_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_TRAP   = 3'd6;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] IMM_SEL_I = 3'd0;
    localparam logic [2:0] IMM_SEL_S = 3'd1;
    localparam logic [2:0] IMM_SEL_B = 3'd2;
    localparam logic [2:0] IMM_SEL_J = 3'd3;
    localparam logic [2:0] IMM_SEL_U = 3'd4;

    localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] PC_SEL_JALR   = 2'd2;

    localparam logic [1:0] ALU_A_RS1  = 2'd0;
    localparam logic [1:0] ALU_A_PC   = 2'd1;
    localparam logic [1:0] ALU_A_ZERO = 2'd2;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    typedef struct packed {
        logic load;
        logic store;
        logic branch;
        logic jal;
        logic jalr;
        logic opImm;
        logic op;
        logic lui;
        logic auipc;
    } inst_class_t;

    // OP has no immediate; it shares code 0 with the I format.
    function automatic logic [2:0] immSelFor(input inst_class_t c);
        logic [2:0] sel;
        sel = IMM_SEL_I;
        if (c.store)              sel = IMM_SEL_S;
        else if (c.branch)        sel = IMM_SEL_B;
        else if (c.jal)           sel = IMM_SEL_J;
        else if (c.lui | c.auipc) sel = IMM_SEL_U;
        return sel;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the sequencer and the core datapath / memory port.
interface multicycle_ctrl_if;
    logic        run;
    logic [31:0] inst;
    logic        mem_ready;
    logic        br_taken;
    logic [2:0]  imm_sel;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic [1:0]  alu_a_sel;
    logic        alu_b_sel;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        mem_req;
    logic        mem_we;
    logic        retire;
    logic        illegal;

    modport master (
        output run, inst, mem_ready, br_taken,
        input  imm_sel, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel,
               rf_we, wb_sel, mem_req, mem_we, retire, illegal
    );

    modport slave (
        input  run, inst, mem_ready, br_taken,
        output imm_sel, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel,
               rf_we, wb_sel, mem_req, mem_we, retire, illegal
    );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational opcode classifier: one-hot instruction class plus an
// illegal flag for any opcode outside the supported RV32I subset.
module mc_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0]  opcode_i,
    output inst_class_t class_o,
    output logic        illegal_o
);

    always_comb begin
        class_o   = '0;
        illegal_o = 1'b0;
        case (opcode_i)
            OPC_LOAD:   class_o.load   = 1'b1;
            OPC_STORE:  class_o.store  = 1'b1;
            OPC_BRANCH: class_o.branch = 1'b1;
            OPC_JAL:    class_o.jal    = 1'b1;
            OPC_JALR:   class_o.jalr   = 1'b1;
            OPC_OP_IMM: class_o.opImm  = 1'b1;
            OPC_OP:     class_o.op     = 1'b1;
            OPC_LUI:    class_o.lui    = 1'b1;
            OPC_AUIPC:  class_o.auipc  = 1'b1;
            default:    illegal_o      = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives the datapath controls as Moore/Mealy outputs.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    multicycle_ctrl_if.slave   bus
);

    logic [2:0]  state_q, state_d;
    inst_class_t cls;
    logic        decIllegal;
    logic        retireNow;

    logic [2:0]  immSel;
    logic        irWe, pcWe, aluBSel, rfWe, memReq, memWe, illegalFlag;
    logic [1:0]  pcSel, aluASel, wbSel;

    // Only the opcode field matters here; the rest of the IR feeds the datapath.
    logic unused_inst;
    assign unused_inst = ^bus.inst[31:7];

    mc_decode uDecode (
        .opcode_i  (bus.inst[6:0]),
        .class_o   (cls),
        .illegal_o (decIllegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        retireNow   = 1'b0;
        immSel      = IMM_SEL_I;
        irWe        = 1'b0;
        pcWe        = 1'b0;
        pcSel       = PC_SEL_PLUS4;
        aluASel     = ALU_A_RS1;
        aluBSel     = 1'b0;
        rfWe        = 1'b0;
        wbSel       = WB_SEL_ALU;
        memReq      = 1'b0;
        memWe       = 1'b0;
        illegalFlag = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                memReq = 1'b1;
                if (bus.mem_ready) begin
                    irWe    = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                immSel  = immSelFor(cls);
                state_d = decIllegal ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
                immSel = immSelFor(cls);
                if (cls.op) begin
                    state_d = ST_WB;
                end else if (cls.opImm) begin
                    aluBSel = 1'b1;
                    state_d = ST_WB;
                end else if (cls.load | cls.store) begin
                    aluBSel = 1'b1;
                    state_d = ST_MEM;
                end else if (cls.lui | cls.auipc) begin
                    aluASel = cls.lui ? ALU_A_ZERO : ALU_A_PC;
                    aluBSel = 1'b1;
                    state_d = ST_WB;
                end else if (cls.branch) begin
                    pcWe      = 1'b1;
                    pcSel     = bus.br_taken ? PC_SEL_BRANCH : PC_SEL_PLUS4;
                    retireNow = 1'b1;
                end else if (cls.jal | cls.jalr) begin
                    rfWe      = 1'b1;
                    wbSel     = WB_SEL_PC4;
                    pcWe      = 1'b1;
                    pcSel     = cls.jal ? PC_SEL_BRANCH : PC_SEL_JALR;
                    retireNow = 1'b1;
                end else begin
                    state_d = ST_TRAP;
                end
            end
            ST_MEM: begin
                immSel = immSelFor(cls);
                memReq = 1'b1;
                memWe  = cls.store;
                if (bus.mem_ready) begin
                    if (cls.store) begin
                        pcWe      = 1'b1;
                        retireNow = 1'b1;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                immSel    = immSelFor(cls);
                rfWe      = 1'b1;
                pcWe      = 1'b1;
                wbSel     = cls.load ? WB_SEL_MEM : WB_SEL_ALU;
                retireNow = 1'b1;
            end
            ST_TRAP: begin
                illegalFlag = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // run is only sampled at retire, so dropping it mid-instruction never aborts.
        if (retireNow) state_d = bus.run ? ST_FETCH : ST_IDLE;
    end

    assign bus.imm_sel   = immSel;
    assign bus.ir_we     = irWe;
    assign bus.pc_we     = pcWe;
    assign bus.pc_sel    = pcSel;
    assign bus.alu_a_sel = aluASel;
    assign bus.alu_b_sel = aluBSel;
    assign bus.rf_we     = rfWe;
    assign bus.wb_sel    = wbSel;
    assign bus.mem_req   = memReq;
    assign bus.mem_we    = memWe;
    assign bus.retire    = retireNow;
    assign bus.illegal   = illegalFlag;

endmodule
